itch_add_order_no_mpid_encoder: RTL

Serialises one ITCH Add Order (no MPID) message from a parallel field bundle into a stream of 64-bit words in the same byte-lane packing that the Add Order receive parser consumes. It sits on the transmit side of the ITCH datapath, between the order-generation logic and the word-stream framer/MAC interface. It accepts one message per input handshake, emits 5 words under valid/ready backpressure, and supports back-to-back messages with no idle cycle.

---
 rtl/itch_pkg.sv | 55 +++++
 rtl/itch_add_order_no_mpid_encoder_if.sv | 35 +++
 rtl/itch_add_order_no_mpid_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/itch_pkg.sv
// Shared ITCH constants and types used by the Add Order (no MPID) encoder and receive parser.
// The bit offsets below define where each field sits in the little-endian message image.
package itch_pkg;

  localparam logic [7:0] MSG_ADD_ORDER_NO_MPID = 8'h41;
  localparam int         ADD_ORDER_WORDS       = 5;
  localparam logic [7:0] ADD_ORDER_LAST_KEEP   = 8'h1F;
  localparam int         ADD_ORDER_IMAGE_BITS  = 64 * ADD_ORDER_WORDS;

  localparam int AO_MSG_TYPE_OFS       = 0;
  localparam int AO_TIMESTAMP_OFS      = 8;
  localparam int AO_ORDER_ID_OFS       = 40;
  localparam int AO_ORDER_BOOK_ID_OFS  = 104;
  localparam int AO_SIDE_OFS           = 136;
  localparam int AO_ORDER_BOOK_POS_OFS = 144;
  localparam int AO_QUANTITY_OFS       = 176;
  localparam int AO_PRICE_OFS          = 240;
  localparam int AO_ORDER_ATTR_OFS     = 272;
  localparam int AO_LOT_TYPE_OFS       = 288;

  typedef struct packed {
    logic [31:0] timeStamp;
    logic [63:0] orderID;
    logic [31:0] orderBookID;
    logic [7:0]  side;
    logic [31:0] orderBookPosition;
    logic [63:0] quantity;
    logic [31:0] price;
    logic [15:0] orderAttributes;
    logic [7:0]  lotType;
  } addOrderFields_t;

  typedef enum logic {
    ENC_IDLE,
    ENC_SEND
  } encState_t;

  // Bytes above lotType stay zero so the final word carries a clean pad.
  function automatic logic [ADD_ORDER_IMAGE_BITS-1:0] buildAddOrderImage(input addOrderFields_t f);
    logic [ADD_ORDER_IMAGE_BITS-1:0] img;
    img = '0;
    img[AO_MSG_TYPE_OFS       +: 8]  = MSG_ADD_ORDER_NO_MPID;
    img[AO_TIMESTAMP_OFS      +: 32] = f.timeStamp;
    img[AO_ORDER_ID_OFS       +: 64] = f.orderID;
    img[AO_ORDER_BOOK_ID_OFS  +: 32] = f.orderBookID;
    img[AO_SIDE_OFS           +: 8]  = f.side;
    img[AO_ORDER_BOOK_POS_OFS +: 32] = f.orderBookPosition;
    img[AO_QUANTITY_OFS       +: 64] = f.quantity;
    img[AO_PRICE_OFS          +: 32] = f.price;
    img[AO_ORDER_ATTR_OFS     +: 16] = f.orderAttributes;
    img[AO_LOT_TYPE_OFS       +: 8]  = f.lotType;
    return img;
  endfunction

endpackage

// File: rtl/itch_add_order_no_mpid_encoder_if.sv
// Field-bundle input handshake and 64-bit word-stream output of the Add Order encoder.
interface itch_add_order_no_mpid_encoder_if;

  logic        inValid;
  logic        inReady;
  logic [31:0] timeStamp;
  logic [63:0] orderID;
  logic [31:0] orderBookID;
  logic [7:0]  side;
  logic [31:0] orderBookPosition;
  logic [63:0] quantity;
  logic [31:0] price;
  logic [15:0] orderAttributes;
  logic [7:0]  lotType;

  logic        outValid;
  logic        outReady;
  logic [63:0] outData;
  logic [7:0]  outKeep;
  logic        outLast;
  logic [2:0]  wordIdx;

  modport master (
    output inValid, timeStamp, orderID, orderBookID, side, orderBookPosition,
           quantity, price, orderAttributes, lotType, outReady,
    input  inReady, outValid, outData, outKeep, outLast, wordIdx
  );

  modport slave (
    input  inValid, timeStamp, orderID, orderBookID, side, orderBookPosition,
           quantity, price, orderAttributes, lotType, outReady,
    output inReady, outValid, outData, outKeep, outLast, wordIdx
  );

endinterface

// File: rtl/itch_add_order_no_mpid_encoder.sv
// Serialises one ITCH Add Order (no MPID) field bundle into five 64-bit words,
// accepting the next bundle on the final beat so messages run back-to-back.
module itch_add_order_no_mpid_encoder
  import itch_pkg::*;
(
  input logic clk,
  input logic rst,
  itch_add_order_no_mpid_encoder_if.slave bus
);

  localparam logic [2:0] LAST_WORD_IDX = 3'(ADD_ORDER_WORDS - 1);

  encState_t                       state, stateNext;
  logic [2:0]                      wordIdxReg, wordIdxNext;
  addOrderFields_t                 holdReg, inFields;
  logic [ADD_ORDER_IMAGE_BITS-1:0] image;
  logic                            capture;
  logic                            inReadyInt;
  logic                            sending;
  logic [63:0]                     wordData;

  always_comb begin
    inFields.timeStamp         = bus.timeStamp;
    inFields.orderID           = bus.orderID;
    inFields.orderBookID       = bus.orderBookID;
    inFields.side              = bus.side;
    inFields.orderBookPosition = bus.orderBookPosition;
    inFields.quantity          = bus.quantity;
    inFields.price             = bus.price;
    inFields.orderAttributes   = bus.orderAttributes;
    inFields.lotType           = bus.lotType;
  end

  // The final beat doubles as an accept slot, which is the only input-to-output path.
  always_comb begin
    stateNext   = state;
    wordIdxNext = wordIdxReg;
    inReadyInt  = 1'b0;
    capture     = 1'b0;
    case (state)
      ENC_IDLE: begin
        inReadyInt = 1'b1;
        if (bus.inValid) begin
          capture     = 1'b1;
          wordIdxNext = 3'd0;
          stateNext   = ENC_SEND;
        end
      end
      ENC_SEND: begin
        if (bus.outReady) begin
          if (wordIdxReg == LAST_WORD_IDX) begin
            inReadyInt  = 1'b1;
            wordIdxNext = 3'd0;
            if (bus.inValid) begin
              capture = 1'b1;
            end else begin
              stateNext = ENC_IDLE;
            end
          end else begin
            wordIdxNext = wordIdxReg + 3'd1;
          end
        end
      end
      default: stateNext = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ENC_IDLE;
      wordIdxReg <= 3'd0;
      holdReg    <= '0;
    end else begin
      state      <= stateNext;
      wordIdxReg <= wordIdxNext;
      if (capture) begin
        holdReg <= inFields;
      end
    end
  end

  assign image   = buildAddOrderImage(holdReg);
  assign sending = (state == ENC_SEND);

  always_comb begin
    wordData = '0;
    case (wordIdxReg)
      3'd0:    wordData = image[63:0];
      3'd1:    wordData = image[127:64];
      3'd2:    wordData = image[191:128];
      3'd3:    wordData = image[255:192];
      3'd4:    wordData = image[319:256];
      default: wordData = '0;
    endcase
  end

  assign bus.inReady  = inReadyInt;
  assign bus.outValid = sending;
  assign bus.wordIdx  = wordIdxReg;
  assign bus.outData  = sending ? wordData : 64'd0;
  assign bus.outLast  = sending && (wordIdxReg == LAST_WORD_IDX);
  assign bus.outKeep  = !sending ? 8'h00 :
                        (wordIdxReg == LAST_WORD_IDX) ? ADD_ORDER_LAST_KEEP : 8'hFF;

endmodule
